// File: rtl/stream_src_ctrl.sv
// Source sequencer for the CDC buffer write side: picks the Fibonacci or timer
// producer, absorbs one late word in a skid register and drains before idling.
module stream_src_ctrl #(
  parameter int unsigned MAX_WORDS = 0,
  parameter int unsigned W         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_f,
  input  logic         start_t,
  input  logic         stop,
  input  logic         f_valid,
  input  logic [W-1:0] f_out,
  input  logic         t_valid,
  input  logic [W-1:0] t_out,
  input  logic         buffer_full,
  input  logic         buffer_empty,
  input  logic         data_2_valid,
  output logic         f_en,
  output logic         t_en,
  output logic         data_1_en,
  output logic [W-1:0] data_1,
  output logic [1:0]   mode,
  output logic         busy,
  output logic [15:0]  word_cnt,
  output logic         drop
);

  localparam int unsigned CW       = 16;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] LIMIT   = CW'(MAX_WORDS);
  localparam logic          LIMIT_ON = (MAX_WORDS != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN_F  = 3'd1;
  localparam logic [2:0] S_RUN_T  = 3'd2;
  localparam logic [2:0] S_WAIT_F = 3'd3;
  localparam logic [2:0] S_WAIT_T = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_FIB  = 2'd1;
  localparam logic [1:0] M_TMR  = 2'd2;

  logic [2:0]    r_state;
  logic          r_skid_vld;
  logic [W-1:0]  r_skid_data;
  logic          r_data_1_en;
  logic [W-1:0]  r_data_1;
  logic [CW-1:0] r_word_cnt;
  logic          r_drop;
  logic [1:0]    r_mode;
  logic          r_f_en;
  logic          r_t_en;
  logic          r_busy;

  logic [2:0]    w_state_nxt;
  logic          w_live_vld;
  logic [W-1:0]  w_live_data;
  logic          w_running;
  logic          w_emit;
  logic [W-1:0]  w_emit_data;
  logic          w_skid_vld_nxt;
  logic [W-1:0]  w_skid_data_nxt;
  logic          w_drop_set;
  logic          w_clear;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_drop_nxt;
  logic [1:0]    w_mode_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_data_1_en <= 1'b0;
      r_data_1    <= '0;
      r_word_cnt  <= '0;
      r_drop      <= 1'b0;
      r_mode      <= M_IDLE;
      r_f_en      <= 1'b0;
      r_t_en      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_data_1_en <= w_emit;
      if (w_emit) begin
        r_data_1 <= w_emit_data;
      end
      r_word_cnt  <= w_cnt_nxt;
      r_drop      <= w_drop_nxt;
      r_mode      <= w_mode_nxt;
      r_f_en      <= (w_state_nxt == S_RUN_F);
      r_t_en      <= (w_state_nxt == S_RUN_T);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Write path, next state and next output values
  always_comb begin
    w_live_vld      = 1'b0;
    w_live_data     = '0;
    w_emit          = 1'b0;
    w_emit_data     = r_data_1;
    w_skid_vld_nxt  = r_skid_vld;
    w_skid_data_nxt = r_skid_data;
    w_drop_set      = 1'b0;
    w_clear         = 1'b0;
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;

    // Only the active source is observed; r_mode is 0 in IDLE
    if (r_mode == M_FIB) begin
      w_live_vld  = f_valid;
      w_live_data = f_out;
    end else if (r_mode == M_TMR) begin
      w_live_vld  = t_valid;
      w_live_data = t_out;
    end

    w_running = (r_state == S_RUN_F) || (r_state == S_RUN_T);

    if (r_skid_vld) begin
      if (!buffer_full) begin
        w_emit         = 1'b1;
        w_emit_data    = r_skid_data;
        w_skid_vld_nxt = w_live_vld;
        if (w_live_vld) begin
          w_skid_data_nxt = w_live_data;
        end
      end else if (w_live_vld) begin
        w_drop_set = 1'b1;
      end
    end else if (w_live_vld) begin
      if (!buffer_full && w_running) begin
        w_emit      = 1'b1;
        w_emit_data = w_live_data;
      end else begin
        w_skid_vld_nxt  = 1'b1;
        w_skid_data_nxt = w_live_data;
      end
    end

    w_cnt_inc = (w_emit && (r_word_cnt != CNT_MAX)) ? r_word_cnt + CW'(1) : r_word_cnt;

    case (r_state)
      S_IDLE: begin
        if (start_f) begin
          w_state_nxt = S_RUN_F;
          w_clear     = 1'b1;
        end else if (start_t) begin
          w_state_nxt = S_RUN_T;
          w_clear     = 1'b1;
        end
      end
      S_RUN_F, S_RUN_T: begin
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end else if (buffer_full) begin
          w_state_nxt = (r_state == S_RUN_F) ? S_WAIT_F : S_WAIT_T;
        end else if (LIMIT_ON && w_emit && (w_cnt_inc == LIMIT)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_WAIT_F: begin
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end else if (!buffer_full) begin
          w_state_nxt = S_RUN_F;
        end
      end
      S_WAIT_T: begin
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end else if (!buffer_full) begin
          w_state_nxt = S_RUN_T;
        end
      end
      S_DRAIN: begin
        // A word landing in the skid this cycle keeps us draining
        if (!w_skid_vld_nxt && buffer_empty && !data_2_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_cnt_nxt  = w_clear ? '0 : w_cnt_inc;
    w_drop_nxt = w_clear ? 1'b0 : (r_drop | w_drop_set);

    case (w_state_nxt)
      S_RUN_F, S_WAIT_F: w_mode_nxt = M_FIB;
      S_RUN_T, S_WAIT_T: w_mode_nxt = M_TMR;
      S_DRAIN:           w_mode_nxt = r_mode;
      default:           w_mode_nxt = M_IDLE;
    endcase
  end

  assign f_en      = r_f_en;
  assign t_en      = r_t_en;
  assign data_1_en = r_data_1_en;
  assign data_1    = r_data_1;
  assign mode      = r_mode;
  assign busy      = r_busy;
  assign word_cnt  = r_word_cnt;
  assign drop      = r_drop;

endmodule

// File: tb/tb_stream_src_ctrl.sv
// Bench for stream_src_ctrl: an unlimited and a 4-word-limited instance share
// stimulus and are each compared every cycle against a behavioural model.
module tb_stream_src_ctrl;

  logic clk = 1'b0;
  logic rst, start_f, start_t, stop;
  logic f_valid, t_valid;
  logic [15:0] f_out, t_out;
  logic buffer_full, buffer_empty, data_2_valid;

  logic u_f_en, u_t_en, u_d1_en, u_busy, u_drop;
  logic [15:0] u_d1, u_cnt;
  logic [1:0] u_mode;
  logic l_f_en, l_t_en, l_d1_en, l_busy, l_drop;
  logic [15:0] l_d1, l_cnt;
  logic [1:0] l_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_src_ctrl #(.MAX_WORDS(0), .W(16)) dut_u (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .f_valid(f_valid), .f_out(f_out), .t_valid(t_valid), .t_out(t_out),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .f_en(u_f_en), .t_en(u_t_en), .data_1_en(u_d1_en), .data_1(u_d1),
    .mode(u_mode), .busy(u_busy), .word_cnt(u_cnt), .drop(u_drop));

  stream_src_ctrl #(.MAX_WORDS(4), .W(16)) dut_l (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .f_valid(f_valid), .f_out(f_out), .t_valid(t_valid), .t_out(t_out),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .f_en(l_f_en), .t_en(l_t_en), .data_1_en(l_d1_en), .data_1(l_d1),
    .mode(l_mode), .busy(l_busy), .word_cnt(l_cnt), .drop(l_drop));

  // Model: phase 0 idle, 1 running, 2 waiting on full, 3 draining; src 1 fib, 2 timer
  typedef struct {
    int          phase;
    logic [1:0]  src;
    logic        skid_v;
    logic [15:0] skid_d;
    logic        d1_en;
    logic [15:0] d1;
    logic [15:0] cnt;
    logic        drop;
  } model_t;

  model_t m_u, m_l;

  function automatic model_t model_zero();
    model_t z;
    z.phase = 0; z.src = 2'd0; z.skid_v = 1'b0; z.skid_d = '0;
    z.d1_en = 1'b0; z.d1 = '0; z.cnt = '0; z.drop = 1'b0;
    return z;
  endfunction

  function automatic model_t model_step(input model_t c, input int limit);
    model_t n;
    logic lv;
    logic [15:0] ld;
    n = c;
    if (rst) return model_zero();
    lv = (c.phase != 0) && ((c.src == 2'd1) ? f_valid : t_valid);
    ld = (c.src == 2'd1) ? f_out : t_out;
    n.d1_en = 1'b0;
    // Oldest word leaves first: skid content, then the live word
    if (c.skid_v && !buffer_full) begin
      n.d1_en = 1'b1; n.d1 = c.skid_d; n.skid_v = 1'b0;
    end else if (!c.skid_v && lv && !buffer_full && c.phase == 1) begin
      n.d1_en = 1'b1; n.d1 = ld; lv = 1'b0;
    end
    if (lv) begin
      if (!n.skid_v) begin n.skid_v = 1'b1; n.skid_d = ld; end
      else n.drop = 1'b1;
    end
    if (n.d1_en && c.cnt != 16'hFFFF) n.cnt = c.cnt + 16'd1;
    case (c.phase)
      0: if (start_f || start_t) begin
           n.phase = 1; n.src = start_f ? 2'd1 : 2'd2; n.cnt = '0; n.drop = 1'b0;
         end
      1: if (stop) n.phase = 3;
         else if (buffer_full) n.phase = 2;
         else if (limit != 0 && n.d1_en && int'(n.cnt) == limit) n.phase = 3;
      2: if (stop) n.phase = 3;
         else if (!buffer_full) n.phase = 1;
      default: if (!n.skid_v && buffer_empty && !data_2_valid) n.phase = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string who, input model_t m,
                         input logic fe, input logic te, input logic de, input logic [15:0] d,
                         input logic [1:0] md, input logic bz, input logic [15:0] wc, input logic dr);
    chk({who, ".f_en"},      32'(fe), 32'(m.phase == 1 && m.src == 2'd1));
    chk({who, ".t_en"},      32'(te), 32'(m.phase == 1 && m.src == 2'd2));
    chk({who, ".data_1_en"}, 32'(de), 32'(m.d1_en));
    chk({who, ".data_1"},    32'(d),  32'(m.d1));
    chk({who, ".mode"},      32'(md), (m.phase == 0) ? 32'd0 : 32'(m.src));
    chk({who, ".busy"},      32'(bz), 32'(m.phase != 0));
    chk({who, ".word_cnt"},  32'(wc), 32'(m.cnt));
    chk({who, ".drop"},      32'(dr), 32'(m.drop));
  endtask

  // One clock: advance both models on the current inputs, then compare after the edge
  task automatic tick();
    model_t nu, nl;
    nu = model_step(m_u, 0);
    nl = model_step(m_l, 4);
    @(posedge clk);
    #1;
    m_u = nu;
    m_l = nl;
    chk_dut("u", m_u, u_f_en, u_t_en, u_d1_en, u_d1, u_mode, u_busy, u_cnt, u_drop);
    chk_dut("l", m_l, l_f_en, l_t_en, l_d1_en, l_d1, l_mode, l_busy, l_cnt, l_drop);
  endtask

  task automatic quiet();
    start_f = 0; start_t = 0; stop = 0; f_valid = 0; t_valid = 0;
    buffer_full = 0; buffer_empty = 1; data_2_valid = 0;
  endtask

  task automatic drain_all();
    quiet();
    stop = 1;
    tick();
    stop = 0;
    for (int k = 0; k < 10 && (u_busy || l_busy); k++) tick();
    chk("drain_idle_u", 32'(u_busy), 32'd0);
    chk("drain_idle_l", 32'(l_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] fib [5];
    int strobes;
    fib[0] = 16'd0; fib[1] = 16'd1; fib[2] = 16'd1; fib[3] = 16'd2; fib[4] = 16'd3;
    m_u = model_zero();
    m_l = model_zero();
    f_out = '0; t_out = '0;
    quiet();

    // Reset
    rst = 1;
    tick(); tick();
    chk("reset_busy", 32'(u_busy), 32'd0);
    chk("reset_mode", 32'(u_mode), 32'd0);
    rst = 0;
    tick();

    // Fibonacci run, no backpressure
    start_f = 1; tick(); start_f = 0;
    chk("fib_f_en", 32'(u_f_en), 32'd1);
    for (int i = 0; i < 5; i++) begin
      f_valid = 1; f_out = fib[i];
      tick();
      chk("fib_strobe", 32'(u_d1_en), 32'd1);
      chk("fib_data", 32'(u_d1), 32'(fib[i]));
      chk("fib_t_en", 32'(u_t_en), 32'd0);
    end
    f_valid = 0;
    tick();
    chk("fib_cnt", 32'(u_cnt), 32'd5);
    drain_all();

    // Backpressure: late word parked in skid, written first on release
    start_f = 1; tick(); start_f = 0;
    f_valid = 1; f_out = 16'h0100; tick();
    f_out = 16'h0101; buffer_full = 1; tick();
    chk("bp_f_en_drop", 32'(u_f_en), 32'd0);
    f_valid = 0; tick(); tick();
    chk("bp_no_strobe", 32'(u_d1_en), 32'd0);
    buffer_full = 0; tick();
    chk("bp_skid_out", 32'(u_d1), 32'h0101);
    chk("bp_skid_strobe", 32'(u_d1_en), 32'd1);
    f_valid = 1; f_out = 16'h0102; tick();
    chk("bp_next", 32'(u_d1), 32'h0102);
    chk("bp_no_drop", 32'(u_drop), 32'd0);
    drain_all();

    // Double overflow in WAIT_T
    start_t = 1; tick(); start_t = 0;
    t_valid = 1; t_out = 16'h0200; tick();
    t_out = 16'h0201; buffer_full = 1; tick();
    t_out = 16'h0202; tick();
    chk("ovf_drop", 32'(u_drop), 32'd1);
    chk("ovf_cnt", 32'(u_cnt), 32'd1);
    t_valid = 0; buffer_full = 0; tick();
    chk("ovf_skid_out", 32'(u_d1), 32'h0201);
    drain_all();
    start_t = 1; tick(); start_t = 0;
    chk("ovf_drop_clear", 32'(u_drop), 32'd0);
    drain_all();

    // Word limit on the 4-word instance, producer follows its enable
    start_t = 1; tick(); start_t = 0;
    buffer_empty = 0; data_2_valid = 1;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      t_valid = l_t_en; t_out = 16'($urandom);
      tick();
      if (l_d1_en) strobes++;
    end
    chk("lim_strobes", 32'(strobes), 32'd4);
    chk("lim_drain_busy", 32'(l_busy), 32'd1);
    chk("lim_drain_t_en", 32'(l_t_en), 32'd0);
    t_valid = 0; buffer_empty = 1; data_2_valid = 0; tick();
    chk("lim_busy_fall", 32'(l_busy), 32'd0);
    drain_all();

    // Start priority, then stop beats buffer_full
    start_f = 1; start_t = 1; tick(); start_f = 0; start_t = 0;
    chk("prio_mode", 32'(u_mode), 32'd1);
    f_valid = 1; f_out = 16'h0300; buffer_full = 1; stop = 1; tick();
    f_valid = 0; stop = 0; buffer_full = 0; buffer_empty = 0; tick();
    chk("stop_drain_f_en", 32'(u_f_en), 32'd0);
    chk("stop_drain_busy", 32'(u_busy), 32'd1);
    chk("stop_drain_mode", 32'(u_mode), 32'd1);
    drain_all();

    // Mid-run reset
    start_t = 1; tick(); start_t = 0;
    t_valid = 1; t_out = 16'h0400; tick();
    t_out = 16'h0401; rst = 1; tick();
    rst = 0;
    chk("rst_busy", 32'(u_busy), 32'd0);
    chk("rst_strobe", 32'(u_d1_en), 32'd0);
    chk("rst_data", 32'(u_d1), 32'd0);
    tick();
    chk("rst_after", 32'(u_d1_en), 32'd0);
    t_valid = 0;
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      start_f      = ($urandom_range(0, 7) == 0);
      start_t      = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 15) == 0);
      f_valid      = ($urandom_range(0, 9) < 7);
      t_valid      = ($urandom_range(0, 9) < 7);
      f_out        = 16'($urandom);
      t_out        = 16'($urandom);
      buffer_full  = ($urandom_range(0, 9) < 3);
      buffer_empty = ($urandom_range(0, 1) == 0);
      data_2_valid = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
